// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and pipeline_hazard_ctrl.
// The datapath side (master) supplies ID/EX/MEM status; the controller side
// (slave) returns stall/flush strobes, forwarding selects and the stall counter.
interface pipeline_hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_we_reg;
  logic        id_mem_read;
  logic        ex_branch_taken;
  logic        mem_busy;

  logic        pc_stall;
  logic        IFIDstall;
  logic        IFIDflush;
  logic        IDEXstall;
  logic        IDEXflush;
  logic        EXMEMstall;
  logic [1:0]  rs1_forwarding;
  logic [1:0]  rs2_forwarding;
  logic [31:0] stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_we_reg, id_mem_read, ex_branch_taken, mem_busy,
    input  pc_stall, IFIDstall, IFIDflush, IDEXstall, IDEXflush, EXMEMstall,
           rs1_forwarding, rs2_forwarding, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_we_reg, id_mem_read, ex_branch_taken, mem_busy,
    output pc_stall, IFIDstall, IFIDflush, IDEXstall, IDEXflush, EXMEMstall,
           rs1_forwarding, rs2_forwarding, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core.
// Tracks shadow copies of the EX and MEM destination records, detects
// load-use hazards, sequences branch redirects (including those that arrive
// while data memory is busy) and produces registered forwarding selects.
module pipeline_hazard_ctrl (
  input  logic                   clk,
  input  logic                   rstn,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_LU_BUBBLE = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT  = 2'd2;
  localparam logic [1:0] ST_REDIRECT  = 2'd3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        br_pending;

  // Shadow stage records
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic        ex_load;
  logic [4:0]  mem_rd;
  logic        mem_we;

  logic [1:0]  rs1_fwd;
  logic [1:0]  rs2_fwd;
  logic [31:0] stall_cnt;

  logic        freeze;
  logic        redirect;
  logic        load_use;
  logic        ex_hit;
  logic        pc_hold;
  logic        idex_flush;

  // Source select for one operand of the instruction moving into EX.
  // The youngest producer (EX) wins over the older one (MEM); x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic       used,
    input logic [4:0] rs,
    input logic [4:0] e_rd,
    input logic       e_we,
    input logic [4:0] m_rd,
    input logic       m_we
  );
    if (!used || rs == 5'd0)        return FWD_RF;
    else if (e_we && e_rd == rs)    return FWD_EX;
    else if (m_we && m_rd == rs)    return FWD_MEM;
    else                            return FWD_RF;
  endfunction

  // Hazard decode: freeze beats redirect beats load-use.
  always_comb begin
    freeze   = hz.mem_busy;
    // A redirect is honoured in RUN, LU_BUBBLE and the MEM_WAIT exit cycle;
    // the pending flag can only be set in MEM_WAIT.
    redirect = !freeze && (state != ST_REDIRECT) &&
               (hz.ex_branch_taken || br_pending);
    ex_hit   = (hz.id_use_rs1 && hz.id_rs1 == ex_rd) ||
               (hz.id_use_rs2 && hz.id_rs2 == ex_rd);
    load_use = !freeze && !redirect && hz.id_valid &&
               (state == ST_RUN || state == ST_MEM_WAIT) &&
               ex_load && ex_we && (ex_rd != 5'd0) && ex_hit;
    pc_hold    = freeze || load_use;
    idex_flush = redirect || load_use;
  end

  // Strobes are forced low while reset is held so the pipeline never sees a
  // stray stall or flush during reset.
  assign hz.pc_stall       = rstn & pc_hold;
  assign hz.IFIDstall      = rstn & pc_hold;
  assign hz.IDEXstall      = rstn & freeze;
  assign hz.EXMEMstall     = rstn & freeze;
  assign hz.IFIDflush      = rstn & redirect;
  assign hz.IDEXflush      = rstn & idex_flush;
  assign hz.rs1_forwarding = rs1_fwd;
  assign hz.rs2_forwarding = rs2_fwd;
  assign hz.stall_cycles   = stall_cnt;

  // Next-state selection for the hazard FSM.
  always_comb begin
    // NOTE: a default assignment first means every path drives state_nxt, so no latch is inferred.
    state_nxt = ST_RUN;
    if (freeze)        state_nxt = ST_MEM_WAIT;
    else if (redirect) state_nxt = ST_REDIRECT;
    else if (load_use) state_nxt = ST_LU_BUBBLE;
  end

  // FSM state and the branch-under-freeze pending flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state      <= ST_RUN;
      br_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      if (freeze)
        br_pending <= br_pending || (hz.ex_branch_taken && state != ST_REDIRECT);
      else
        br_pending <= 1'b0;
    end
  end

  // Shadow records and forwarding selects shift only on non-frozen edges.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_rd   <= 5'd0;
      ex_we   <= 1'b0;
      ex_load <= 1'b0;
      mem_rd  <= 5'd0;
      mem_we  <= 1'b0;
      rs1_fwd <= FWD_RF;
      rs2_fwd <= FWD_RF;
    end else if (!freeze) begin
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      if (idex_flush) begin
        ex_rd   <= 5'd0;
        ex_we   <= 1'b0;
        ex_load <= 1'b0;
        rs1_fwd <= FWD_RF;
        rs2_fwd <= FWD_RF;
      end else begin
        ex_rd   <= hz.id_rd;
        ex_we   <= hz.id_we_reg;
        ex_load <= hz.id_mem_read;
        rs1_fwd <= fwd_sel(hz.id_use_rs1, hz.id_rs1, ex_rd, ex_we, mem_rd, mem_we);
        rs2_fwd <= fwd_sel(hz.id_use_rs2, hz.id_rs2, ex_rd, ex_we, mem_rd, mem_we);
      end
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cnt <= 32'd0;
    else if (pc_hold && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// random traffic, checked cycle by cycle against an instruction-level model.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rstn;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .hz   (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       valid;
    bit [4:0] rs1;
    bit       u1;
    bit [4:0] rs2;
    bit       u2;
    bit [4:0] rd;
    bit       we;
    bit       ld;
    bit       br;
    bit       busy;
  } stim_t;

  typedef struct {
    bit        pc_stall;
    bit        ifid_stall;
    bit        ifid_flush;
    bit        idex_stall;
    bit        idex_flush;
    bit        exmem_stall;
    bit [1:0]  f1;
    bit [1:0]  f2;
    bit [31:0] cnt;
  } exp_t;

  typedef struct {
    bit [4:0] rd;
    bit       we;
    bit       ld;
  } instr_t;

  // What the pipeline is doing in the current cycle from the model's view.
  typedef enum int {P_NORMAL, P_BUBBLE, P_WAITING, P_AFTER_REDIRECT} phase_e;

  exp_t   sb[$];
  int     total = 0;
  int     bad   = 0;

  instr_t m_ex, m_mem;
  phase_e m_phase;
  bit     m_owed;
  bit [1:0] m_f1, m_f2;
  longint m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  function automatic stim_t mk(bit valid, int rs1, bit u1, int rs2, bit u2,
                               int rd, bit we, bit ld, bit br, bit busy);
    stim_t s;
    s.rst = 1'b0; s.valid = valid;
    s.rs1 = 5'(rs1); s.u1 = u1; s.rs2 = 5'(rs2); s.u2 = u2;
    s.rd = 5'(rd); s.we = we; s.ld = ld; s.br = br; s.busy = busy;
    return s;
  endfunction

  function automatic stim_t rst_stim(bit br, bit busy);
    stim_t s;
    s = mk(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, br, busy);
    s.rst = 1'b1;
    return s;
  endfunction

  // Which older instruction (if any) supplies a source operand.
  function automatic bit [1:0] producer(bit used, bit [4:0] rs);
    if (!used || rs == 0)                 return 2'd0;
    if (m_ex.we && m_ex.rd == rs)         return 2'd1;
    if (m_mem.we && m_mem.rd == rs)       return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_ex = '{default: 0};
    m_mem = '{default: 0};
    m_phase = P_NORMAL;
    m_owed = 1'b0;
    m_f1 = 2'd0;
    m_f2 = 2'd0;
    m_cnt = 0;
  endtask

  // Drive one cycle of inputs, queue the expected response, advance the model.
  task automatic step(input stim_t s);
    exp_t   e;
    bit     take_branch, bubble;
    instr_t id;
    hz.id_valid = s.valid; hz.id_rs1 = s.rs1; hz.id_rs2 = s.rs2;
    hz.id_use_rs1 = s.u1; hz.id_use_rs2 = s.u2; hz.id_rd = s.rd;
    hz.id_we_reg = s.we; hz.id_mem_read = s.ld;
    hz.ex_branch_taken = s.br; hz.mem_busy = s.busy;
    rstn = !s.rst;
    e = '{default: 0};
    if (s.rst) begin
      model_reset();
      sb.push_back(e);
      @(posedge clk); #1;
      return;
    end
    e.f1 = m_f1; e.f2 = m_f2; e.cnt = 32'(m_cnt);
    if (s.busy) begin
      e.pc_stall = 1; e.ifid_stall = 1; e.idex_stall = 1; e.exmem_stall = 1;
      if (s.br && m_phase != P_AFTER_REDIRECT) m_owed = 1'b1;
      m_phase = P_WAITING;
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end else begin
      take_branch = (m_phase != P_AFTER_REDIRECT) && (s.br || m_owed);
      bubble = !take_branch && s.valid &&
               (m_phase == P_NORMAL || m_phase == P_WAITING) &&
               m_ex.ld && m_ex.we && m_ex.rd != 0 &&
               ((s.u1 && s.rs1 == m_ex.rd) || (s.u2 && s.rs2 == m_ex.rd));
      e.ifid_flush = take_branch;
      e.idex_flush = take_branch || bubble;
      e.pc_stall = bubble;
      e.ifid_stall = bubble;
      m_owed = 1'b0;
      if (bubble && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      id.rd = s.rd; id.we = s.we; id.ld = s.ld;
      if (take_branch || bubble) begin
        m_f1 = 0; m_f2 = 0;
      end else begin
        m_f1 = producer(s.u1, s.rs1);
        m_f2 = producer(s.u2, s.rs2);
      end
      m_mem = m_ex;
      m_ex = (take_branch || bubble) ? '{default: 0} : id;
      m_phase = take_branch ? P_AFTER_REDIRECT : (bubble ? P_BUBBLE : P_NORMAL);
    end
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc_stall",   32'(hz.pc_stall),       32'(e.pc_stall));
        check("IFIDstall",  32'(hz.IFIDstall),      32'(e.ifid_stall));
        check("IFIDflush",  32'(hz.IFIDflush),      32'(e.ifid_flush));
        check("IDEXstall",  32'(hz.IDEXstall),      32'(e.idex_stall));
        check("IDEXflush",  32'(hz.IDEXflush),      32'(e.idex_flush));
        check("EXMEMstall", 32'(hz.EXMEMstall),     32'(e.exmem_stall));
        check("rs1_fwd",    32'(hz.rs1_forwarding), 32'(e.f1));
        check("rs2_fwd",    32'(hz.rs2_forwarding), 32'(e.f2));
        check("stall_cnt",  hz.stall_cycles,        e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    rstn = 1'b0;
    model_reset();
    s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    hz.id_valid = 0; hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_use_rs1 = 0;
    hz.id_use_rs2 = 0; hz.id_rd = 0; hz.id_we_reg = 0; hz.id_mem_read = 0;
    hz.ex_branch_taken = 0; hz.mem_busy = 0;
    @(posedge clk); #1;

    // Reset with busy and branch driven: all strobes must stay low.
    step(rst_stim(1'b1, 1'b1));
    step(rst_stim(1'b1, 1'b1));

    // Load-use: lw x5 then add x6,x5,x7.
    step(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0));
    step(mk(1, 5, 1, 7, 1, 6, 1, 0, 0, 0));
    step(mk(1, 5, 1, 7, 1, 6, 1, 0, 0, 0));
    check("lu_rs1_fwd", 32'(hz.rs1_forwarding), 32'd2);
    check("lu_rs2_fwd", 32'(hz.rs2_forwarding), 32'd0);
    check("lu_stall_cnt", hz.stall_cycles, 32'd1);

    // ALU back-to-back: add x3 then sub x4,x3,x3.
    step(rst_stim(0, 0));
    step(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0));
    step(mk(1, 3, 1, 3, 1, 4, 1, 0, 0, 0));
    check("alu_rs1_fwd", 32'(hz.rs1_forwarding), 32'd1);
    check("alu_rs2_fwd", 32'(hz.rs2_forwarding), 32'd1);

    // x0 never forwards; EX beats MEM for the same register.
    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    step(mk(1, 0, 1, 0, 1, 8, 1, 0, 0, 0));
    check("x0_rs1_fwd", 32'(hz.rs1_forwarding), 32'd0);
    check("x0_rs2_fwd", 32'(hz.rs2_forwarding), 32'd0);
    step(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0));
    step(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0));
    step(mk(1, 9, 1, 9, 1, 10, 1, 0, 0, 0));
    check("prio_rs1_fwd", 32'(hz.rs1_forwarding), 32'd1);
    check("prio_rs2_fwd", 32'(hz.rs2_forwarding), 32'd1);

    // Branch under a 3-cycle freeze, redirect in the 4th cycle.
    step(rst_stim(0, 0));
    repeat (3) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("frz_stall_cnt", hz.stall_cycles, 32'd3);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Branch together with a load-use: flush only, counter untouched.
    step(rst_stim(0, 0));
    step(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0));
    step(mk(1, 5, 1, 0, 0, 6, 1, 0, 1, 0));
    check("br_lu_stall_cnt", hz.stall_cycles, 32'd0);
    step(mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0));

    // Reset during MEM_WAIT with a pending branch: no redirect afterwards.
    repeat (2) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    step(rst_stim(1, 1));
    repeat (3) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset during LU_BUBBLE.
    step(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0));
    step(mk(1, 0, 0, 7, 1, 2, 1, 0, 0, 0));
    step(rst_stim(0, 0));
    repeat (2) step(mk(1, 0, 0, 7, 1, 2, 1, 0, 0, 0));

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      s.rst   = ($urandom_range(0, 99) == 0);
      s.valid = ($urandom_range(0, 5) != 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.u1    = $urandom_range(0, 3) != 0;
      s.u2    = $urandom_range(0, 1) != 0;
      s.rd    = 5'($urandom_range(0, 3));
      s.we    = $urandom_range(0, 3) != 0;
      s.ld    = $urandom_range(0, 2) == 0;
      s.br    = $urandom_range(0, 7) == 0;
      s.busy  = $urandom_range(0, 4) == 0;
      step(s);
    end

    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rstn  input  1  asynchronous active-low reset.
REQ-002 The block SHALL have these inputs: id_valid 1 (ID holds a real instruction); id_rs1, id_rs2 5 (source register indices); id_use_rs1, id_use_rs2 1 (source is read); id_rd 5 (destination index); id_we_reg 1 (writes a register); id_mem_read 1 (is a load); ex_branch_taken 1 (EX redirects the PC); mem_busy 1 (data memory not ready).
REQ-003 The block SHALL have these outputs: pc_stall 1; IFIDstall 1; IFIDflush 1; IDEXstall 1; IDEXflush 1; EXMEMstall 1; rs1_forwarding, rs2_forwarding 2 (registered forwarding selects for the EX-stage instruction); stall_cycles 32 (performance counter).
REQ-004 The forwarding encoding SHALL be 2'b00 for the register file, 2'b01 for the EX/MEM result and 2'b10 for the MEM/WB write-back data (rd_data); 2'b11 SHALL never be driven.

Function
REQ-005 The block SHALL keep shadow stage records {rd, we, load} for EX and {rd, we} for MEM.
- On each non-frozen clock, ID->EX and EX->MEM SHALL shift.
- The EX record SHALL load zero when a bubble or flush is inserted.
REQ-006 The FSM SHALL have states RUN, LU_BUBBLE, MEM_WAIT and REDIRECT, and SHALL reset to RUN.
REQ-007 Freeze: while mem_busy=1 in any state, pc_stall, IFIDstall, IDEXstall and EXMEMstall SHALL all be 1.
- Both flushes SHALL be 0.
- Shadows and forwarding selects SHALL hold.
- The state SHALL be MEM_WAIT on the next edge.
REQ-008 Load-use hazard: in RUN, with id_valid=1, the EX record a load with rd!=0 and we=1, and rd matching a used source, the block SHALL assert pc_stall=1, IFIDstall=1 and IDEXflush=1 (IDEXstall=0) combinationally, and enter LU_BUBBLE.
REQ-009 LU_BUBBLE SHALL last exactly one cycle with no stall or flush outputs, then return to RUN; the ID instruction SHALL then advance with forwarding 2'b10 from the load.
REQ-010 Redirect: ex_branch_taken=1 in RUN or LU_BUBBLE SHALL assert IFIDflush=1 and IDEXflush=1 in the same cycle, with no stalls, and enter REDIRECT.
- REDIRECT SHALL last one cycle with no outputs, then return to RUN.
REQ-011 Priority SHALL be mem_busy > ex_branch_taken > load-use.
REQ-012 A branch that coincides with mem_busy SHALL set a pending flag; the redirect flushes SHALL be issued in the first cycle after mem_busy deasserts, and the flag SHALL then clear.
REQ-013 MEM_WAIT SHALL exit to REDIRECT if the pending flag is set, otherwise to RUN; a load-use hazard SHALL be re-evaluated in the exit cycle.
REQ-014 Forwarding SHALL be updated only on edges where ID->EX advances (IDEXstall=0, IDEXflush=0).
- Select 2'b01 if the current EX record has we=1, rd!=0 and rd==rs.
- Otherwise select 2'b10 if the MEM record matches under the same conditions.
- Otherwise select 2'b00.
- An unused source, or rs=0, SHALL give 2'b00.
REQ-015 On flush edges, both forwarding selects SHALL load 2'b00.
REQ-016 stall_cycles SHALL increment on every edge where pc_stall=1, and SHALL saturate at 32'hFFFF_FFFF.
REQ-017 id_valid=0 SHALL suppress load-use detection only; freeze and redirect SHALL still apply.

Reset
REQ-018 When rstn=0, regardless of clk, state SHALL be RUN, the pending flag 0, all shadow records 0, rs1/rs2_forwarding 2'b00 and stall_cycles 0.
REQ-019 Because every output is gated by state and reset, all stall and flush outputs SHALL be 0 while rstn=0.
REQ-020 Reset asserted mid-MEM_WAIT or mid-LU_BUBBLE SHALL discard the operation, with no pending redirect surviving.

Verification
REQ-021 Load-use: EX holds lw x5; ID is add x6,x5,x7 -> one cycle of pc_stall=IFIDstall=IDEXflush=1, then the add advances with rs1_forwarding=2'b10 and rs2_forwarding=2'b00; stall_cycles=1.
REQ-022 ALU back-to-back: EX holds add x3 (we=1); ID is sub x4,x3,x3 -> no stall; after the edge rs1_forwarding=rs2_forwarding=2'b01.
REQ-023 x0 and priority: EX writes x0; ID reads x0 -> forwarding 2'b00. Hazard in both EX and MEM for the same register -> 2'b01.
REQ-024 Branch under freeze: ex_branch_taken=1 with mem_busy=1 for 3 cycles -> 3 freeze cycles with no flush; IFIDflush=IDEXflush=1 exactly in the 4th cycle; stall_cycles=3.
REQ-025 Simultaneous branch and load-use -> flushes only, with no pc_stall, state REDIRECT, and stall_cycles unchanged.
REQ-026 Reset mid-MEM_WAIT with a branch pending -> all outputs 0 and counter 0; after release and mem_busy=0, no flush occurs.
